rq_req_arbiter: RTL and testbench
=================================

Name: rq_req_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single requester-request (RQ) TLP stream between NUM_REQ TLP sources, e.g. the DMA reader, the DMA writer and MSI.
- Sources use the 128-bit legacy-header stream format. The arbiter output drives the RQ adapter input.
- A packet is never interleaved with another.
- Outstanding non-posted reads are throttled against a credit limit; completion-side logic releases each credit.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_RD_OUTSTANDING, 32, maximum outstanding read requests (1..255).
- CNT_W, $clog2(MAX_RD_OUTSTANDING+1), width of the read counter.

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  NUM_REQ  per-requester valid.
- s_tready  out  NUM_REQ  per-requester ready.
- s_tlast  in  NUM_REQ  per-requester end of packet.
- s_tdata  in  128*NUM_REQ  requester i occupies slice [128*i+127:128*i].
- s_tkeep  in  16*NUM_REQ  byte enables.
- s_tuser  in  4*NUM_REQ  {unused, discontinue, poison, ecrc}, passed through.
- m_tvalid  out  1  output valid.
- m_tready  in  4  downstream ready; only bit 0 is used.
- m_tlast  out  1  output end of packet.
- m_tdata  out  128  output data.
- m_tkeep  out  16  output byte enables.
- m_tuser  out  4  output user bits.
- rd_done  in  1  one-cycle pulse: one outstanding read fully completed.
- rd_outstanding  out  CNT_W  current outstanding read count.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- rd_underflow  out  1  sticky: rd_done was received while the count was 0.

Behaviour:
- States: IDLE and PASS.
- Reset, asynchronous, any time including mid-packet:
  - State returns to IDLE; grant = 0; round-robin pointer = 0.
  - rd_outstanding = 0; rd_underflow = 0.
  - m_tvalid = 0; s_tready = 0.
  - m_tdata, m_tkeep, m_tuser and m_tlast are 0.
- In IDLE, all m_* outputs are 0 and all s_tready are 0.
- Read detection: first beat of a packet with s_tdata[31:30] == 2'b00 (a header with no data).
- Eligibility: requester i is eligible when s_tvalid[i] = 1, and, if its first beat is a read, rd_outstanding < MAX_RD_OUTSTANDING.
- Arbitration (IDLE):
  - Search starts at the pointer and wraps modulo NUM_REQ; the first eligible requester wins.
  - On the next edge: grant <= one-hot(winner), pointer <= (winner+1) mod NUM_REQ, state <= PASS.
  - With no eligible requester, stay in IDLE.
  - Latency from s_tvalid to m_tvalid is 1 cycle; there is exactly one bubble cycle between consecutive packets.
- PASS: combinational pass-through of the granted requester g, no buffering.
  - m_tvalid = s_tvalid[g]; m_tdata, m_tkeep, m_tuser and m_tlast come from g.
  - s_tready[g] = m_tready[0]; every other s_tready = 0.
  - The owner may drop s_tvalid mid-packet; the grant holds.
- End of packet: a beat accepted with m_tvalid & m_tready[0] & m_tlast sends the state to IDLE and sets grant to 0.
- Read counter:
  - Increments by 1 when the first beat of a read packet is accepted on m_*.
  - Decrements by 1 on rd_done.
  - Increment and rd_done in the same cycle: count unchanged.
  - rd_done with count 0: count stays 0 and rd_underflow is set.
  - The counter never exceeds MAX_RD_OUTSTANDING, by the eligibility rule.
- A blocked read requester does not block others: a write or an eligible read from another requester is granted.
- Single-beat packets (first beat also has tlast) are legal; read detection and the count increment apply to that beat.

Test Plan:
1. Reset with all s_tvalid = 1 -> during reset, grant = 0, m_tvalid = 0 and s_tready = 0. After reset, req0 is granted at cycle 1, then req1 after req0's tlast, then req0 again (round-robin alternation).
2. req0 sends a 3-beat write while req1 asserts a read in the same cycle -> m_* shows req0's 3 beats contiguously with s_tready[1] = 0 throughout. One bubble cycle follows, then req1's read; rd_outstanding goes 0 -> 1.
3. MAX_RD_OUTSTANDING = 2: issue 2 reads from req0, then a third read from req0 and a write from req1 -> the req1 write is granted and the req0 read stalls. A rd_done pulse returns the count to 1, and on the next IDLE cycle req0 is granted.
4. Read header accepted in the same cycle as rd_done, with count at 1 -> count stays 1.
5. rd_done with count 0 -> count stays 0, rd_underflow goes to 1 and stays 1 until reset.
6. Owner drops s_tvalid for 2 cycles mid-packet, and separately m_tready[0] = 0 for 3 cycles -> grant is held, no beats are lost or duplicated, and the beat order on m_tdata is preserved.

Source files
------------

// File: rtl/rq_req_arbiter_if.sv
// Requester-request stream bundle: NUM_REQ legacy-header sources in,
// one merged 128-bit stream out. The slave modport is the arbiter side.
interface rq_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]     s_tvalid;
    logic [NUM_REQ-1:0]     s_tready;
    logic [NUM_REQ-1:0]     s_tlast;
    logic [128*NUM_REQ-1:0] s_tdata;
    logic [16*NUM_REQ-1:0]  s_tkeep;
    logic [4*NUM_REQ-1:0]   s_tuser;

    logic                   m_tvalid;
    logic [3:0]             m_tready;
    logic                   m_tlast;
    logic [127:0]           m_tdata;
    logic [15:0]            m_tkeep;
    logic [3:0]             m_tuser;

    modport slave (
        input  s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser
    );

    modport master (
        output s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser
    );
endinterface

// File: rtl/rq_req_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ RQ TLP sources onto one
// stream, throttling outstanding non-posted reads against a credit limit.
// Ports: user_clk/user_reset (async, active high); bus = s_* sources and
// m_* merged output; rd_done releases one read credit; rd_outstanding is
// the live read count; grant is the one-hot owner; rd_underflow is sticky.
module rq_req_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int MAX_RD_OUTSTANDING = 32,
    parameter int CNT_W              = $clog2(MAX_RD_OUTSTANDING + 1)
) (
    input  logic               user_clk,
    input  logic               user_reset,
    rq_req_arbiter_if.slave    bus,
    input  logic               rd_done,
    output logic [CNT_W-1:0]   rd_outstanding,
    output logic [NUM_REQ-1:0] grant,
    output logic               rd_underflow
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, PASS} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               first;

    logic [NUM_REQ-1:0] is_rd;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     idx;
    logic               fire;
    logic               inc;
    logic               unused_ready;

    assign unused_ready = ^bus.m_tready[3:1];

    // A header-only TLP (fmt = 00) is a non-posted read.
    always_comb begin
        is_rd = '0;
        elig  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_rd[i] = (bus.s_tdata[128*i+30 +: 2] == 2'b00);
            elig[i]  = bus.s_tvalid[i] &&
                       (!is_rd[i] ||
                        rd_outstanding < CNT_W'(MAX_RD_OUTSTANDING));
        end
    end

    // Rotating search starting at ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ))
                idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!found && elig[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    // Unbuffered pass-through of the owner while a packet is in flight.
    always_comb begin
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tkeep  = '0;
        bus.m_tuser  = '0;
        bus.s_tready = '0;
        if (state == PASS) begin
            bus.m_tvalid        = bus.s_tvalid[owner];
            bus.m_tlast         = bus.s_tlast[owner];
            bus.m_tdata         = bus.s_tdata[{owner, 7'd0} +: 128];
            bus.m_tkeep         = bus.s_tkeep[{owner, 4'd0} +: 16];
            bus.m_tuser         = bus.s_tuser[{owner, 2'd0} +: 4];
            bus.s_tready[owner] = bus.m_tready[0];
        end
    end

    assign fire = (state == PASS) && bus.m_tvalid && bus.m_tready[0];
    assign inc  = fire && first && is_rd[owner];

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            first <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= PASS;
                        owner <= win;
                        grant <= NUM_REQ'(1) << win;
                        first <= 1'b1;
                        ptr   <= (win == PTR_W'(NUM_REQ - 1)) ?
                                 '0 : win + 1'b1;
                    end
                end
                PASS: begin
                    if (fire) begin
                        first <= 1'b0;
                        if (bus.m_tlast) begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A simultaneous issue and release cancel out.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            rd_outstanding <= '0;
            rd_underflow   <= 1'b0;
        end else if (inc && !rd_done) begin
            rd_outstanding <= rd_outstanding + 1'b1;
        end else if (rd_done && !inc) begin
            if (rd_outstanding == '0)
                rd_underflow <= 1'b1;
            else
                rd_outstanding <= rd_outstanding - 1'b1;
        end
    end
endmodule

// File: tb/tb_rq_req_arbiter.sv
// Bench for rq_req_arbiter: per-source packet queues, a cycle-level
// reference model compared every cycle, and directed scenario checks.
module tb_rq_req_arbiter;
    localparam int N     = 2;
    localparam int MAXRD = 2;
    localparam int CW    = $clog2(MAXRD + 1);

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic [3:0]   user;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_done = 1'b0;
    logic [CW-1:0] rd_out;
    logic [N-1:0]  grant;
    logic          uf;

    logic [N-1:0]     sv = '0;
    logic [N-1:0]     sl = '0;
    logic [128*N-1:0] sd = '0;
    logic [16*N-1:0]  sk = '0;
    logic [4*N-1:0]   su = '0;
    logic [3:0]       mrdy = 4'b0001;

    rq_req_arbiter_if #(.NUM_REQ(N)) bus ();

    assign bus.s_tvalid = sv;
    assign bus.s_tlast  = sl;
    assign bus.s_tdata  = sd;
    assign bus.s_tkeep  = sk;
    assign bus.s_tuser  = su;
    assign bus.m_tready = mrdy;

    rq_req_arbiter #(
        .NUM_REQ(N),
        .MAX_RD_OUTSTANDING(MAXRD)
    ) dut (
        .user_clk(clk),
        .user_reset(rst),
        .bus(bus),
        .rd_done(rd_done),
        .rd_outstanding(rd_out),
        .grant(grant),
        .rd_underflow(uf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus sources ----------------
    beat_t        q[N][$];
    int           seq_gen[N];
    int           exp_seq[N];
    int           hold[N];
    logic [N-1:0] acc = '0;

    task automatic add_pkt(int src, bit rd, int nb);
        beat_t b;
        logic [7:0] s;
        for (int j = 0; j < nb; j++) begin
            s = seq_gen[src][7:0];
            b = '0;
            b.data        = {16{s}};
            b.data[31:30] = (j == 0) ? (rd ? 2'b00 : 2'b01) : 2'b11;
            b.data[11:8]  = src[3:0];
            b.data[7:0]   = s;
            b.keep        = (j == nb - 1) ? 16'h00ff : 16'hffff;
            b.user        = s[3:0];
            b.last        = (j == nb - 1);
            q[src].push_back(b);
            seq_gen[src]++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            beat_t cur;
            if (acc[i] && q[i].size() > 0)
                void'(q[i].pop_front());
            cur = (q[i].size() > 0) ? q[i][0] : '0;
            if (hold[i] > 0) begin
                hold[i]--;
                sv[i] = 1'b0;
            end else begin
                sv[i] = (q[i].size() > 0);
            end
            sl[i]            = cur.last;
            sd[128*i +: 128] = cur.data;
            sk[16*i +: 16]   = cur.keep;
            su[4*i +: 4]     = cur.user;
        end
    end

    // ---------------- reference model + compare ----------------
    int           m_owner = -1;
    int           m_ptr = 0;
    int           m_cnt = 0;
    bit           m_uf = 1'b0;
    bit           m_first = 1'b0;
    int           cyc = 0;
    int           fc[$];
    int           fsrc[$];
    logic [N-1:0] glog[$];
    logic [N-1:0] prev_g = '0;

    always @(negedge clk) begin
        logic         e_v, e_l, m_fire, m_inc, found;
        logic [127:0] e_d;
        logic [15:0]  e_k;
        logic [3:0]   e_u;
        logic [N-1:0] e_r, e_g;
        int           o, mi, src;

        cyc++;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_uf    = 1'b0;
            m_first = 1'b0;
        end

        e_v = 1'b0; e_l = 1'b0; e_d = '0; e_k = '0; e_u = '0;
        e_r = '0;   e_g = '0;
        o = m_owner;
        if (o >= 0) begin
            e_v = sv[o];
            e_l = sl[o];
            e_d = sd[128*o +: 128];
            e_k = sk[16*o +: 16];
            e_u = su[4*o +: 4];
            e_g = N'(1) << o;
            e_r = mrdy[0] ? e_g : '0;
        end
        chk("grant", grant, e_g);
        chk("m_tvalid", bus.m_tvalid, e_v);
        chk("m_tlast", bus.m_tlast, e_l);
        chk("m_tdata", bus.m_tdata, e_d);
        chk("m_tkeep", bus.m_tkeep, e_k);
        chk("m_tuser", bus.m_tuser, e_u);
        chk("s_tready", bus.s_tready, e_r);
        chk("rd_outstanding", rd_out, m_cnt);
        chk("rd_underflow", uf, m_uf);

        acc = bus.s_tvalid & bus.s_tready;

        if (bus.m_tvalid && bus.m_tready[0]) begin
            src = int'(bus.m_tdata[11:8]);
            if (src < N) begin
                chk("beat_order", bus.m_tdata[7:0], exp_seq[src][7:0]);
                exp_seq[src]++;
            end else begin
                chk("beat_source", src, 0);
            end
            fc.push_back(cyc);
            fsrc.push_back(src);
        end
        if (grant != 0 && prev_g == 0)
            glog.push_back(grant);
        prev_g = grant;

        if (!rst) begin
            m_inc = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    mi = (m_ptr + k) % N;
                    if (!found && sv[mi] &&
                        (sd[128*mi+30 +: 2] != 2'b00 || m_cnt < MAXRD)) begin
                        found   = 1'b1;
                        m_owner = mi;
                        m_ptr   = (mi + 1) % N;
                        m_first = 1'b1;
                    end
                end
            end else begin
                m_fire = sv[o] && mrdy[0];
                if (m_fire) begin
                    m_inc   = m_first && (sd[128*o+30 +: 2] == 2'b00);
                    m_first = 1'b0;
                    if (sl[o])
                        m_owner = -1;
                end
            end
            if (m_inc && !rd_done) begin
                m_cnt++;
            end else if (rd_done && !m_inc) begin
                if (m_cnt == 0) m_uf = 1'b1;
                else m_cnt--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 rd_done = 1'b1;
        @(posedge clk); #1 rd_done = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int c = 0;
        bit done = 1'b0;
        while (!done && c < maxc) begin
            @(negedge clk);
            c++;
            done = (q[0].size() == 0) && (q[1].size() == 0) && (grant == 0);
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL wait_idle: timed out after %0d cycles", c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        // 1: valid held through reset, then round-robin alternation
        add_pkt(0, 0, 2);
        add_pkt(0, 0, 2);
        add_pkt(1, 0, 2);
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_count", rd_out, 0);
        @(posedge clk); #1 rst = 1'b0;
        glog.delete();
        @(negedge clk);
        chk("cyc0_grant", grant, 0);
        @(negedge clk);
        chk("cyc1_grant", grant, 2'b01);
        wait_idle(40);
        chk("rr_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("rr_first", glog[0], 2'b01);
            chk("rr_second", glog[1], 2'b10);
            chk("rr_third", glog[2], 2'b01);
        end

        // 2: 3-beat write vs single-beat read arriving together
        do_reset();
        fc.delete();
        fsrc.delete();
        add_pkt(0, 0, 3);
        add_pkt(1, 1, 1);
        wait_idle(40);
        chk("p2_beats", fc.size(), 4);
        if (fc.size() == 4) begin
            chk("p2_src_a", fsrc[2], 0);
            chk("p2_src_b", fsrc[3], 1);
            chk("p2_contig", fc[2] - fc[0], 2);
            chk("p2_bubble", fc[3] - fc[2], 2);
        end
        chk("p2_count", rd_out, 1);

        // 3: credit limit reached, write bypasses the stalled read
        do_reset();
        add_pkt(0, 1, 1);
        add_pkt(0, 1, 1);
        wait_idle(40);
        chk("p3_count_full", rd_out, 2);
        glog.delete();
        add_pkt(0, 1, 1);
        add_pkt(1, 0, 2);
        repeat (8) @(negedge clk);
        chk("p3_write_first", (glog.size() == 1) ? glog[0] : 2'b00, 2'b10);
        chk("p3_read_stalled", q[0].size(), 1);
        chk("p3_idle", grant, 0);
        @(posedge clk); #1 rd_done = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rd_done = 1'b0;
        @(negedge clk);
        chk("p3_count_rel", rd_out, 1);
        chk("p3_idle_cycle", grant, 0);
        @(negedge clk);
        chk("p3_read_grant", grant, 2'b01);
        wait_idle(40);
        chk("p3_count_end", rd_out, 2);

        // 4: read header accepted in the same cycle as rd_done
        pulse_done();
        @(negedge clk);
        chk("p4_count_pre", rd_out, 1);
        add_pkt(0, 1, 1);
        @(posedge clk); #2;
        @(posedge clk); #1 rd_done = 1'b1;
        @(negedge clk);
        chk("p4_grant", grant, 2'b01);
        chk("p4_accept", bus.m_tvalid & bus.m_tready[0], 1'b1);
        @(posedge clk); #1 rd_done = 1'b0;
        @(negedge clk);
        chk("p4_count_same", rd_out, 1);

        // 5: release below zero
        pulse_done();
        @(negedge clk);
        chk("p5_count_zero", rd_out, 0);
        chk("p5_no_uf", uf, 0);
        pulse_done();
        @(negedge clk);
        chk("p5_count_floor", rd_out, 0);
        chk("p5_uf", uf, 1);
        repeat (3) @(negedge clk);
        chk("p5_uf_sticky", uf, 1);
        do_reset();
        @(negedge clk);
        chk("p5_uf_clear", uf, 0);

        // 6: source gap and downstream stall inside a packet
        fc.delete();
        fsrc.delete();
        add_pkt(0, 0, 6);
        c = 0;
        while (grant != 2'b01 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("p6_granted", grant, 2'b01);
        @(posedge clk); #2 hold[0] = 2;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("p6_gap_grant", grant, 2'b01);
            chk("p6_gap_valid", bus.m_tvalid, 0);
        end
        @(negedge clk);
        @(posedge clk); #1 mrdy = 4'b1110;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("p6_stall_grant", grant, 2'b01);
            chk("p6_stall_ready", bus.s_tready, 0);
        end
        @(posedge clk); #1 mrdy = 4'b0001;
        wait_idle(40);
        chk("p6_beats", fc.size(), 6);
        if (fc.size() == 6)
            chk("p6_span", fc[5] - fc[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
